// File: rtl/spi_regfile_rw.sv
// spi_regfile_rw: oversampled SPI peripheral with a read/write NUM_REGS x DATA_W register bank
// Ports: clk, rst (async, active-low); cs_n/sclk/copi async SPI inputs; cipo/cipo_oe read data and
// its tristate enable; regs_flat register bank (reg i at [i*DATA_W +: DATA_W]); wr_strobe/wr_addr
// write-commit pulse and last committed address; frame_err pulse when a frame is discarded.
module spi_regfile_rw #(
  parameter int   ADDR_W      = 7,
  parameter int   DATA_W      = 8,
  parameter int   NUM_REGS    = 5,
  parameter int   SYNC_STAGES = 2,
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cs_n,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_copi_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [FRAME_LEN-1:0] r_sr;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic r_rw, r_ovr, r_oe;
  logic w_cs_fall, w_cs_rise, w_cs_lo, w_lead, w_trail, w_sample, w_shift;
  logic w_commit, w_err, w_wr_hit, w_load;
  logic [DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= {SYNC_STAGES{CPOL}};
      r_copi_sync <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
    end
  // Stage SYNC_STAGES-2 holds the newer value, SYNC_STAGES-1 the older one
  assign w_cs_fall = r_cs_sync[SYNC_STAGES-1] & ~r_cs_sync[SYNC_STAGES-2];
  assign w_cs_rise = ~r_cs_sync[SYNC_STAGES-1] & r_cs_sync[SYNC_STAGES-2];
  assign w_cs_lo   = ~r_cs_sync[SYNC_STAGES-2];
  assign w_lead    = (r_sclk_sync[SYNC_STAGES-1] == CPOL) && (r_sclk_sync[SYNC_STAGES-2] != CPOL);
  assign w_trail   = (r_sclk_sync[SYNC_STAGES-1] != CPOL) && (r_sclk_sync[SYNC_STAGES-2] == CPOL);
  assign w_sample  = (CPHA ? w_trail : w_lead) && (r_state != IDLE) && w_cs_lo;
  assign w_shift   = (CPHA ? w_lead : w_trail) && (r_state != IDLE) && w_cs_lo;
  assign w_wr_addr = r_sr[DATA_W +: ADDR_W];
  assign w_rd_addr = r_sr[ADDR_W-1:0];
  // Copi is taken from the older stage so it is always settled when the sample edge is seen
  always_comb begin
    w_rd_data = '0;
    w_wr_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_rd_data = (w_rd_addr == ADDR_W'(i)) ? r_regs[i] : w_rd_data;
      w_wr_hit = w_wr_hit | (w_wr_addr == ADDR_W'(i));
    end
  end
  assign w_commit = w_cs_rise && (r_state == DONE) && !r_ovr && r_sr[FRAME_LEN-1] && w_wr_hit;
  assign w_err    = w_cs_rise && (r_state != IDLE) && ((r_state != DONE) || r_ovr);
  // Read data loads on the first shift edge after the last address bit has been sampled
  assign w_load   = w_shift && !r_oe && !r_rw && (r_state == DATA) && (r_cnt == CNT_W'(1 + ADDR_W));
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_cs_fall ? CMD : IDLE;
    else if (w_cs_rise) w_next = IDLE;
    else if (w_sample)
      case (r_state)
        CMD:     w_next = ADDR;
        ADDR:    w_next = (r_cnt == CNT_W'(ADDR_W)) ? DATA : ADDR;
        DATA:    w_next = (r_cnt == CNT_W'(FRAME_LEN - 1)) ? DONE : DATA;
        default: w_next = r_state;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt     <= '0;
      r_sr      <= '0;
      r_tx      <= '0;
      r_rw      <= 1'b0;
      r_ovr     <= 1'b0;
      r_oe      <= 1'b0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      wr_strobe <= w_commit;
      frame_err <= w_err;
      if (r_state == IDLE || w_cs_rise) begin
        r_cnt <= '0;
        r_sr  <= '0;
        r_tx  <= '0;
        r_rw  <= 1'b0;
        r_ovr <= 1'b0;
        r_oe  <= 1'b0;
      end else begin
        if (w_sample) begin
          r_cnt <= (r_cnt == CNT_W'(FRAME_LEN)) ? r_cnt : r_cnt + 1'b1;
          r_sr  <= {r_sr[FRAME_LEN-2:0], r_copi_sync[SYNC_STAGES-1]};
          r_rw  <= (r_state == CMD) ? r_copi_sync[SYNC_STAGES-1] : r_rw;
          r_ovr <= r_ovr | (r_state == DONE);
        end
        if (w_load) begin
          r_tx <= w_rd_data;
          r_oe <= 1'b1;
        end else if (w_shift && r_oe) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end
      if (w_commit) wr_addr <= w_wr_addr;
      for (int i = 0; i < NUM_REGS; i++)
        if (w_commit && w_wr_addr == ADDR_W'(i)) r_regs[i] <= r_sr[DATA_W-1:0];
    end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end
  assign cipo    = r_oe & r_tx[DATA_W-1];
  assign cipo_oe = r_oe;
endmodule

// File: tb/tb_spi_regfile_rw.sv
// tb_spi_regfile_rw: randomized check of spi_regfile_rw in all four SPI modes against a register-array model
module tb_spi_regfile_rw;
  localparam int HALF = 40;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic copi = 1'b0;
  logic [3:0] cs_n = 4'b1111;
  logic [3:0] sclk = 4'b1100;
  logic [3:0] cipo, cipo_oe, wr_strobe, frame_err;
  logic [39:0] regs_flat [4];
  logic [6:0] wr_addr [4];
  int n_chk = 0;
  int n_fail = 0;
  int n_stb [4] = '{default: 0};
  int n_err [4] = '{default: 0};
  logic [7:0] model [4][5];
  logic [6:0] last_wa [4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_regfile_rw #(.CPOL(1'(g / 2)), .CPHA(1'(g % 2))) u_dut (
      .clk(clk), .rst(rst), .cs_n(cs_n[g]), .sclk(sclk[g]), .copi(copi),
      .cipo(cipo[g]), .cipo_oe(cipo_oe[g]), .regs_flat(regs_flat[g]),
      .wr_strobe(wr_strobe[g]), .wr_addr(wr_addr[g]), .frame_err(frame_err[g])
    );
  end
  always @(negedge clk)
    for (int k = 0; k < 4; k++) begin
      n_stb[k] += int'(wr_strobe[k]);
      n_err[k] += int'(frame_err[k]);
    end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5; i++) model[k][i] = 8'h00;
      last_wa[k] = 7'd0;
    end
  endtask
  function automatic logic [39:0] flat(input int m);
    flat = '0;
    for (int i = 0; i < 5; i++) flat[i*8 +: 8] = model[m][i];
  endfunction
  task automatic frame(input int m, input int nb, input logic [15:0] f, input int rst_at);
    logic cp, ch, rw, exp_stb, ok;
    logic [6:0] a;
    logic [7:0] d, rx, exp_rx;
    logic [31:0] oe_v, oe_e;
    int s0, e0;
    cp = 1'(m / 2);
    ch = 1'(m % 2);
    rw = f[15];
    a = f[14:8];
    d = f[7:0];
    s0 = n_stb[m];
    e0 = n_err[m];
    oe_v = '0;
    oe_e = '0;
    rx = '0;
    cs_n[m] = 1'b0;
    #HALF;
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        rst = 1'b0;
        #20;
        cs_n[m] = 1'b1;
        sclk[m] = cp;
        #40;
        rst = 1'b1;
        #80;
        model_clear();
        check("abort_stb", n_stb[m] - s0, 0);
        check("abort_err", n_err[m] - e0, 0);
        check("abort_regs", regs_flat[m], flat(m));
        check("abort_wa", wr_addr[m], 0);
        return;
      end
      if (ch) sclk[m] = ~cp;
      copi = (i < 16) ? f[15-i] : 1'b0;
      #HALF;
      oe_v[i] = cipo_oe[m];
      oe_e[i] = !rw && (i >= 8);
      if (i >= 8 && i < 16) rx[15-i] = cipo[m];
      sclk[m] = ch ? cp : ~cp;
      #HALF;
      if (!ch) sclk[m] = cp;
    end
    #HALF;
    cs_n[m] = 1'b1;
    #100;
    ok = (nb == 16);
    exp_stb = ok && rw && (a < 5);
    exp_rx = 8'h00;
    if (a < 5) exp_rx = model[m][a];
    if (exp_stb) begin
      model[m][a] = d;
      last_wa[m] = a;
    end
    check("stb", n_stb[m] - s0, exp_stb);
    check("err", n_err[m] - e0, !ok);
    check("regs", regs_flat[m], flat(m));
    check("wa", wr_addr[m], last_wa[m]);
    check("oe", oe_v, oe_e);
    check("idle", {cipo_oe[m], cipo[m]}, 0);
    if (!rw && nb >= 16) check("rx", rx, exp_rx);
  endtask
  initial begin
    logic [15:0] f;
    int nb, r;
    model_clear();
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      check("rst_regs", regs_flat[m], 0);
      check("rst_out", {cipo_oe[m], cipo[m], wr_strobe[m], frame_err[m], wr_addr[m]}, 0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      frame(m, 16, 16'h8480, -1);
      frame(m, 16, 16'h82A5, -1);
      frame(m, 16, 16'h0200, -1);
      frame(m, 12, 16'h8133, -1);
      frame(m, 17, 16'h8133, -1);
      frame(m, 16, 16'hFFFF, -1);
      frame(m, 16, 16'h1000, -1);
      for (int j = 0; j < 25; j++) begin
        f[15] = 1'($urandom_range(0, 1));
        f[14:8] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 5));
        f[7:0] = 8'($urandom);
        r = $urandom_range(0, 9);
        nb = (r == 0) ? $urandom_range(1, 15) : (r == 1) ? 17 : 16;
        frame(m, nb, f, -1);
      end
    end
    frame(0, 16, 16'h8155, 10);
    frame(0, 16, 16'h813C, -1);
    check("final_r1", regs_flat[0][15:8], 8'h3C);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
    $finish;
  end
endmodule
